// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RSP  = 2'd2
    } arb_state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way round-robin picker
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_vld,
    output logic       gnt_idx
);

    assign gnt_vld = |req;

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        gnt_idx = M0;
        if (req == 2'b11) begin
            gnt_idx = ~last;
        end else if (req[1]) begin
            gnt_idx = M1;
        end
    end

endmodule

// File: rtl/mem_port_arb.sv
// rtl/mem_port_arb.sv - two-requester single-outstanding memory port arbiter
module mem_port_arb
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            m0_cmd_valid,
    output logic            m0_cmd_ready,
    input  logic [AW-1:0]   m0_cmd_addr,
    input  logic            m0_cmd_wen,
    input  logic [DW-1:0]   m0_cmd_wdata,
    input  logic [DW/8-1:0] m0_cmd_wmask,
    output logic            m0_rsp_valid,
    input  logic            m0_rsp_ready,
    output logic [DW-1:0]   m0_rsp_rdata,
    output logic            m0_rsp_err,

    input  logic            m1_cmd_valid,
    output logic            m1_cmd_ready,
    input  logic [AW-1:0]   m1_cmd_addr,
    input  logic            m1_cmd_wen,
    input  logic [DW-1:0]   m1_cmd_wdata,
    input  logic [DW/8-1:0] m1_cmd_wmask,
    output logic            m1_rsp_valid,
    input  logic            m1_rsp_ready,
    output logic [DW-1:0]   m1_rsp_rdata,
    output logic            m1_rsp_err,

    output logic            s_cmd_valid,
    input  logic            s_cmd_ready,
    output logic [AW-1:0]   s_cmd_addr,
    output logic            s_cmd_wen,
    output logic [DW-1:0]   s_cmd_wdata,
    output logic [DW/8-1:0] s_cmd_wmask,
    input  logic            s_rsp_valid,
    output logic            s_rsp_ready,
    input  logic [DW-1:0]   s_rsp_rdata,
    input  logic            s_rsp_err
);

    arb_state_e r_state;
    logic       r_own;
    logic       r_last;

    logic       w_in_cmd;
    logic       w_in_rsp;
    logic       w_own_rsp_ready;
    logic       w_rsp_hs;
    logic       w_free;
    logic       w_pick_vld;
    logic       w_pick_idx;
    logic       w_new_grant;
    logic       w_issue;
    logic       w_cur;
    logic       w_cmd_hs;

    assign w_in_cmd = (r_state == CMD);
    assign w_in_rsp = (r_state == RSP);

    assign w_own_rsp_ready = r_own ? m1_rsp_ready : m0_rsp_ready;
    assign w_rsp_hs        = w_in_rsp & s_rsp_valid & w_own_rsp_ready;

    // Completing a response frees the port in the same cycle, so the next
    // grant goes out with no bubble; this makes rsp handshake -> s_cmd_valid
    // a deliberate combinational path.
    assign w_free = (r_state == IDLE) | w_rsp_hs;

    rr_pick2 u_pick (
        .req     ({m1_cmd_valid, m0_cmd_valid}),
        .last    (r_last),
        .gnt_vld (w_pick_vld),
        .gnt_idx (w_pick_idx)
    );

    assign w_new_grant = w_free & w_pick_vld;
    assign w_issue     = w_in_cmd | w_new_grant;
    assign w_cur       = w_in_cmd ? r_own : (w_new_grant & w_pick_idx);
    assign w_cmd_hs    = w_issue & s_cmd_ready;

    assign s_cmd_valid = w_issue;
    assign s_cmd_addr  = w_cur ? m1_cmd_addr  : m0_cmd_addr;
    assign s_cmd_wen   = w_cur ? m1_cmd_wen   : m0_cmd_wen;
    assign s_cmd_wdata = w_cur ? m1_cmd_wdata : m0_cmd_wdata;
    assign s_cmd_wmask = w_cur ? m1_cmd_wmask : m0_cmd_wmask;

    assign m0_cmd_ready = w_cmd_hs & ~w_cur;
    assign m1_cmd_ready = w_cmd_hs &  w_cur;

    assign s_rsp_ready  = w_in_rsp & w_own_rsp_ready;
    assign m0_rsp_valid = w_in_rsp & ~r_own & s_rsp_valid;
    assign m1_rsp_valid = w_in_rsp &  r_own & s_rsp_valid;
    assign m0_rsp_rdata = s_rsp_rdata;
    assign m1_rsp_rdata = s_rsp_rdata;
    assign m0_rsp_err   = s_rsp_err;
    assign m1_rsp_err   = s_rsp_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_own   <= M0;
            r_last  <= M1;
        end else if (w_cmd_hs) begin
            r_state <= RSP;
            r_own   <= w_cur;
            r_last  <= w_cur;
        end else if (w_new_grant) begin
            r_state <= CMD;
            r_own   <= w_cur;
        end else if (w_rsp_hs) begin
            r_state <= IDLE;
        end
    end

endmodule
